evt_rcrd_fifo_packer: RTL and testbench



---
 rtl/evt_rcrd_fifo_packer.sv | 130 +++++++++++++
 tb/tb_evt_rcrd_fifo_packer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_rcrd_fifo_packer.sv
// Timestamps OQ event strobes, packs them into 32-bit records with time-marker
// insertion, and buffers them in a first-word-fall-through FIFO.
module evt_rcrd_fifo_packer #(
    parameter int SIG_VALUE_SIZE  = 8,
    parameter int SIGNAL_ID_SIZE  = 3,
    parameter int NUM_SIGNALS     = 3,
    parameter int FIFO_DEPTH_BITS = 5,
    parameter int TS_LOW_BITS     = 19,
    parameter int TS_WIDTH        = TS_LOW_BITS + 30
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_SIGNALS-1:0]                oq_signals,
    input  logic [NUM_SIGNALS*SIGNAL_ID_SIZE-1:0] oq_signal_ids,
    input  logic [NUM_SIGNALS*SIG_VALUE_SIZE-1:0] oq_signal_values,
    input  logic                                  enable_events,
    input  logic                                  evt_rd_en,
    output logic [31:0]                           evt_word,
    output logic                                  evt_empty,
    output logic [FIFO_DEPTH_BITS:0]              evt_count,
    output logic [31:0]                           evt_drop_count
);

    localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
    localparam int PW      = FIFO_DEPTH_BITS;
    localparam int CW      = FIFO_DEPTH_BITS + 1;
    localparam int HI_BITS = TS_WIDTH - TS_LOW_BITS;

    logic [TS_WIDTH-1:0] ts;
    logic [HI_BITS-1:0]  last_marker_hi;
    logic                need_marker;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count_q;
    logic [31:0]         drop_q;
    logic [31:0]         mem [DEPTH];

    logic [HI_BITS-1:0]  ts_hi;
    logic [31:0]         grp [4];
    logic [2:0]          grp_n;
    logic                marker_req;
    logic                active;
    logic                fits;
    logic                do_write;
    logic                do_drop;
    logic                do_pop;
    logic [CW-1:0]       free_slots;

    assign ts_hi = ts[TS_WIDTH-1:TS_LOW_BITS];

    // Compact marker (if any) and the set strobes into consecutive group slots.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            grp[k] = '0;
        end
        grp_n      = '0;
        marker_req = need_marker || (ts_hi != last_marker_hi);
        if (marker_req) begin
            grp[0][HI_BITS-1:0] = ts_hi;
            grp_n               = 3'd1;
        end
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (oq_signals[i]) begin
                grp[grp_n[1:0]][31:30]                   = 2'(i + 1);
                grp[grp_n[1:0]][27 +: SIGNAL_ID_SIZE]    = oq_signal_ids[i*SIGNAL_ID_SIZE +: SIGNAL_ID_SIZE];
                grp[grp_n[1:0]][19 +: SIG_VALUE_SIZE]    = oq_signal_values[i*SIG_VALUE_SIZE +: SIG_VALUE_SIZE];
                grp[grp_n[1:0]][TS_LOW_BITS-1:0]         = ts[TS_LOW_BITS-1:0];
                grp_n                                    = grp_n + 3'd1;
            end
        end
    end

    // Space is judged against the pre-pop occupancy so a group never depends on a same-cycle read.
    assign free_slots = CW'(DEPTH) - count_q;
    assign active     = enable_events && (|oq_signals);
    assign fits       = (CW'(grp_n) <= free_slots);
    assign do_write   = active && fits;
    assign do_drop    = active && !fits;
    assign do_pop     = evt_rd_en && (count_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ts             <= '0;
            last_marker_hi <= '0;
            need_marker    <= 1'b1;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            drop_q         <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
            if (do_write) begin
                wr_ptr <= wr_ptr + PW'(grp_n);
                if (marker_req) begin
                    last_marker_hi <= ts_hi;
                    need_marker    <= 1'b0;
                end
            end
            if (do_drop) begin
                need_marker <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + 32'd1;
                end
            end
            if (!enable_events) begin
                need_marker <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + (do_write ? CW'(grp_n) : CW'(0)) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < grp_n) begin
                    mem[wr_ptr + PW'(k)] <= grp[k];
                end
            end
        end
    end

    assign evt_empty      = (count_q == '0);
    assign evt_count      = count_q;
    assign evt_word       = evt_empty ? 32'd0 : mem[rd_ptr];
    assign evt_drop_count = drop_q;

endmodule

// File: tb/tb_evt_rcrd_fifo_packer.sv
// Scoreboard bench for evt_rcrd_fifo_packer; a short timestamp-low field keeps
// the marker boundary reachable within a few thousand cycles.
module tb_evt_rcrd_fifo_packer;

    localparam int TSL = 10;
    localparam int TSW = TSL + 30;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  oq_signals;
    logic [8:0]  oq_signal_ids;
    logic [23:0] oq_signal_values;
    logic        enable_events;
    logic        evt_rd_en;
    logic [31:0] evt_word;
    logic        evt_empty;
    logic [5:0]  evt_count;
    logic [31:0] evt_drop_count;

    evt_rcrd_fifo_packer #(
        .SIG_VALUE_SIZE(8), .SIGNAL_ID_SIZE(3), .NUM_SIGNALS(3),
        .FIFO_DEPTH_BITS(5), .TS_LOW_BITS(TSL), .TS_WIDTH(TSW)
    ) dut (
        .clk(clk), .reset(reset), .oq_signals(oq_signals),
        .oq_signal_ids(oq_signal_ids), .oq_signal_values(oq_signal_values),
        .enable_events(enable_events), .evt_rd_en(evt_rd_en),
        .evt_word(evt_word), .evt_empty(evt_empty),
        .evt_count(evt_count), .evt_drop_count(evt_drop_count)
    );

    always #5 clk = ~clk;

    logic [TSW-1:0] m_ts;
    logic [29:0]    m_hi;
    bit             m_need;
    int             m_count;
    int             m_drop;
    logic [31:0]    sb [$];
    int             n_checks = 0;
    int             n_fail = 0;

    // Drive one cycle of stimulus and advance the reference model across the edge.
    task automatic cycle(input logic [2:0] sig, input logic [8:0] ids,
                         input logic [23:0] vals, input logic en, input logic rd);
        int n;
        int c0;
        bit mreq;
        logic [31:0] rec;
        oq_signals       = sig;
        oq_signal_ids    = ids;
        oq_signal_values = vals;
        enable_events    = en;
        evt_rd_en        = rd;
        c0 = m_count;
        if (en && sig != 3'b000) begin
            mreq = m_need || (m_ts[TSW-1:TSL] != m_hi);
            n = int'(mreq) + $countones(sig);
            if (n <= 32 - c0) begin
                if (mreq) begin
                    sb.push_back({2'b00, m_ts[TSW-1:TSL]});
                    m_hi   = m_ts[TSW-1:TSL];
                    m_need = 1'b0;
                end
                for (int i = 0; i < 3; i++) begin
                    if (sig[i]) begin
                        rec = '0;
                        rec[31:30]   = 2'(i + 1);
                        rec[29:27]   = ids[3*i +: 3];
                        rec[26:19]   = vals[8*i +: 8];
                        rec[TSL-1:0] = m_ts[TSL-1:0];
                        sb.push_back(rec);
                    end
                end
                m_count = m_count + n;
            end else begin
                m_drop++;
                m_need = 1'b1;
            end
        end
        if (!en) m_need = 1'b1;
        if (rd && c0 > 0) m_count--;
        @(posedge clk);
        m_ts = m_ts + 1'b1;
        #1;
        oq_signals = '0;
        evt_rd_en  = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(3'b000, 9'd0, 24'd0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        oq_signals = '0;
        evt_rd_en = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_ts    = '0;
        m_hi    = '0;
        m_need  = 1'b1;
        m_count = 0;
        m_drop  = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        do_reset();
        n_checks++;
        if (evt_empty !== 1'b1 || evt_count !== 6'd0 || evt_word !== 32'd0 || evt_drop_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: empty=%b count=%0d word=%h drops=%0d, want 1/0/0/0",
                     evt_empty, evt_count, evt_word, evt_drop_count);
        end
        idle(5);
        cycle(3'b001, {3'd0, 3'd0, 3'd2}, {8'h00, 8'h00, 8'h40}, 1'b1, 1'b0);
        n_checks++;
        if (evt_count !== 6'd2 || evt_word !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL first_group: count=%0d head=%h, want 2 / 00000000", evt_count, evt_word);
        end
        exp = sb.pop_front();
        cycle(3'b000, 9'd0, 24'd0, 1'b1, 1'b1);
        exp = sb.pop_front();
        n_checks++;
        if (evt_word !== 32'h5200_0005 || exp !== 32'h5200_0005) begin
            n_fail++;
            $display("FAIL first_event: got %h, want 52000005", evt_word);
        end
        cycle(3'b000, 9'd0, 24'd0, 1'b1, 1'b1);
        n_checks++;
        if (evt_empty !== 1'b1 || evt_count !== 6'd0) begin
            n_fail++;
            $display("FAIL first_drain: empty=%b count=%0d, want 1/0", evt_empty, evt_count);
        end
    endtask

    task automatic test_all_three();
        logic [31:0] exp;
        int guard = 0;
        cycle(3'b111, {3'd1, 3'd3, 3'd1}, {8'h30, 8'h20, 8'h10}, 1'b1, 1'b0);
        n_checks++;
        if (evt_count !== 6'd3) begin
            n_fail++;
            $display("FAIL all_three_count: got %0d, want 3", evt_count);
        end
        while (sb.size() > 0 && guard < 64) begin
            exp = sb.pop_front();
            n_checks++;
            if (evt_word !== exp || evt_empty !== 1'b0) begin
                n_fail++;
                $display("FAIL all_three_rec: got %h empty=%b, want %h", evt_word, evt_empty, exp);
            end
            cycle(3'b000, 9'd0, 24'd0, 1'b1, 1'b1);
            guard++;
        end
    endtask

    task automatic test_ts_cross();
        logic [31:0] exp;
        int j = 0;
        do_reset();
        idle(1020);
        cycle(3'b001, {3'd0, 3'd0, 3'd5}, {8'h00, 8'h00, 8'h11}, 1'b1, 1'b0);
        idle(5);
        n_checks++;
        if (evt_count !== 6'd2) begin
            n_fail++;
            $display("FAIL idle_no_marker: count=%0d, want 2", evt_count);
        end
        cycle(3'b001, {3'd0, 3'd0, 3'd6}, {8'h00, 8'h00, 8'h22}, 1'b1, 1'b0);
        n_checks++;
        if (evt_count !== 6'd4) begin
            n_fail++;
            $display("FAIL cross_count: count=%0d, want 4", evt_count);
        end
        while (sb.size() > 0 && j < 64) begin
            exp = sb.pop_front();
            n_checks++;
            if (evt_word !== exp || (j == 2 && evt_word !== 32'h0000_0001)) begin
                n_fail++;
                $display("FAIL cross_rec%0d: got %h, want %h", j, evt_word, exp);
            end
            cycle(3'b000, 9'd0, 24'd0, 1'b1, 1'b1);
            j++;
        end
    endtask

    task automatic test_fill_drop();
        logic [31:0] exp;
        int guard = 0;
        do_reset();
        for (int i = 0; i < 29; i++)
            cycle(3'b001, 9'(i), 24'(i * 3), 1'b1, 1'b0);
        n_checks++;
        if (evt_count !== 6'd30) begin
            n_fail++;
            $display("FAIL fill30: count=%0d, want 30", evt_count);
        end
        cycle(3'b111, {3'd1, 3'd2, 3'd3}, 24'h0a0b0c, 1'b1, 1'b0);
        n_checks++;
        if (evt_count !== 6'd30 || evt_drop_count !== 32'd1) begin
            n_fail++;
            $display("FAIL group_drop: count=%0d drops=%0d, want 30/1", evt_count, evt_drop_count);
        end
        cycle(3'b001, 9'd4, 24'h55, 1'b1, 1'b0);
        n_checks++;
        if (evt_count !== 6'd32) begin
            n_fail++;
            $display("FAIL refill_marker: count=%0d, want 32", evt_count);
        end
        exp = sb.pop_front();
        n_checks++;
        if (evt_word !== exp) begin
            n_fail++;
            $display("FAIL full_head: got %h, want %h", evt_word, exp);
        end
        cycle(3'b001, 9'd7, 24'h66, 1'b1, 1'b1);
        n_checks++;
        if (evt_count !== 6'd31 || evt_drop_count !== 32'd2 || evt_count !== 6'(m_count)) begin
            n_fail++;
            $display("FAIL full_pop_push: count=%0d drops=%0d, want 31/2", evt_count, evt_drop_count);
        end
        while (sb.size() > 0 && guard < 64) begin
            exp = sb.pop_front();
            n_checks++;
            if (evt_word !== exp) begin
                n_fail++;
                $display("FAIL fill_drain%0d: got %h, want %h", guard, evt_word, exp);
            end
            cycle(3'b000, 9'd0, 24'd0, 1'b1, 1'b1);
            guard++;
        end
        cycle(3'b000, 9'd0, 24'd0, 1'b1, 1'b1);
        n_checks++;
        if (evt_count !== 6'd0 || evt_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_read: count=%0d empty=%b, want 0/1", evt_count, evt_empty);
        end
        cycle(3'b011, 9'o12, 24'h0102, 1'b1, 1'b0);
        do_reset();
        n_checks++;
        if (evt_count !== 6'd0 || evt_empty !== 1'b1 || evt_drop_count !== 32'd0 || evt_word !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d empty=%b drops=%0d word=%h, want 0/1/0/0",
                     evt_count, evt_empty, evt_drop_count, evt_word);
        end
    endtask

    task automatic test_enable_toggle();
        logic [31:0] exp;
        int guard = 0;
        do_reset();
        cycle(3'b001, 9'd1, 24'h12, 1'b1, 1'b0);
        exp = sb.pop_front();
        cycle(3'b000, 9'd0, 24'd0, 1'b1, 1'b1);
        exp = sb.pop_front();
        cycle(3'b000, 9'd0, 24'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(3'b111, 9'h1ff, 24'hffffff, 1'b0, 1'b0);
        n_checks++;
        if (evt_count !== 6'd0 || evt_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL disabled_capture: count=%0d empty=%b, want 0/1", evt_count, evt_empty);
        end
        cycle(3'b100, {3'd2, 3'd0, 3'd0}, {8'h77, 8'h00, 8'h00}, 1'b1, 1'b0);
        n_checks++;
        if (evt_count !== 6'd2 || evt_word[31:30] !== 2'b00) begin
            n_fail++;
            $display("FAIL reenable_marker: count=%0d type=%b, want 2/00", evt_count, evt_word[31:30]);
        end
        while (sb.size() > 0 && guard < 64) begin
            exp = sb.pop_front();
            n_checks++;
            if (evt_word !== exp) begin
                n_fail++;
                $display("FAIL reenable_rec: got %h, want %h", evt_word, exp);
            end
            cycle(3'b000, 9'd0, 24'd0, 1'b1, 1'b1);
            guard++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        logic        rd;
        int guard = 0;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            rd = 1'($urandom_range(0, 1));
            if (rd && m_count > 0) begin
                exp = sb.pop_front();
                n_checks++;
                if (evt_word !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_rec%0d: got %h, want %h", i, evt_word, exp);
                end
            end
            cycle(3'($urandom_range(0, 7)), 9'($urandom), 24'($urandom), 1'b1, rd);
            n_checks++;
            if (evt_count !== 6'(m_count) || evt_drop_count !== 32'(m_drop)) begin
                n_fail++;
                $display("FAIL b2b_count%0d: count=%0d drops=%0d, want %0d/%0d",
                         i, evt_count, evt_drop_count, m_count, m_drop);
            end
        end
        while (sb.size() > 0 && guard < 64) begin
            exp = sb.pop_front();
            n_checks++;
            if (evt_word !== exp) begin
                n_fail++;
                $display("FAIL b2b_drain: got %h, want %h", evt_word, exp);
            end
            cycle(3'b000, 9'd0, 24'd0, 1'b1, 1'b1);
            guard++;
        end
    endtask

    initial begin
        reset = 1'b1;
        oq_signals = '0;
        oq_signal_ids = '0;
        oq_signal_values = '0;
        enable_events = 1'b1;
        evt_rd_en = 1'b0;
        test_reset();
        test_all_three();
        test_ts_cross();
        test_fill_drop();
        test_enable_toggle();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
